counter_7seg_multi: RTL and testbench
=====================================

// Module: counter_7seg_multi
// PURPOSE
//  Parametrised N-digit up/down counter with 7-segment drive for board demos and status readouts.
//  Selectable display mode: per-bit binary, hexadecimal or BCD decimal.
//  Built-in prescaler, synchronous load, enable and wrap pulse.
//  Sits between the board clock/reset and the HEXn segment pins.
// PARAMETERS
//  DIGITS          4           number of 7-seg digits driven (1..8)
//  CLK_DIV         50_000_000  clk cycles per count step (>=1; 1 = step every enabled cycle)
//  SEG_ACTIVE_LOW  1           1: segment lit = 0 on seg; 0: segment lit = 1
// PORTS
//  clk       in   1           clock
//  reset     in   1           asynchronous, active-high reset
//  en        in   1           count enable (gates both prescaler and counter)
//  up        in   1           1 = count up, 0 = count down
//  mode      in   2           00 BIN, 01 HEX, 10 BCD, 11 reserved (treated as HEX)
//  load      in   1           synchronous load strobe
//  load_val  in   4*DIGITS    value for load (nibble i -> digit i)
//  seg       out  7*DIGITS    seg[7i+6:7i] = digit i, bit order {g,f,e,d,c,b,a}
//  count     out  4*DIGITS    current counter value
//  tick      out  1           1-cycle pulse when the prescaler issues a count step
//  wrap      out  1           1-cycle pulse coincident with a step that wraps
// BEHAVIOUR
//  Reset (async): prescaler=0, count=0, tick=0, wrap=0, mode_q=mode, seg = glyph '0' on every digit.
//  Prescaler: counts 0..CLK_DIV-1 while en=1, holds while en=0.
//   tick=1 on the cycle it wraps to 0; with CLK_DIV=1, tick=en.
//  Step: on tick, count advances one in direction up, per mode:
//   BIN: only count[DIGITS-1:0] used, upper bits 0; range 0..2^DIGITS-1.
//   HEX: range 0..2^(4*DIGITS)-1, plain binary.
//   BCD: each nibble 0..9, decimal ripple carry/borrow; range 0..10^DIGITS-1.
//  Wrap: up from max -> 0, or down from 0 -> max; wrap=1 for that one cycle, registered with count.
//  Priority (same cycle): mode change > load > step.
//   Mode change (mode != mode_q): count=0, prescaler=0, no tick/wrap; mode_q<=mode.
//   Load: count<=load_val sanitised for current mode: BIN keeps low DIGITS bits; BCD clamps each
//    nibble >9 to 9; HEX as-is. Load also clears prescaler; tick may still assert; wrap=0.
//  Display: seg registered; reflects count one cycle after count changes (latency 1).
//   BIN: digit i shows '1' if count[i] else '0'.
//   HEX/BCD: digit i shows nibble i using active-high gfedcba glyphs 0..F =
//    3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71; inverted when SEG_ACTIVE_LOW=1.
//  en=0: count, prescaler frozen; load and mode change still act.
//  Reset mid-count: immediate return to reset values regardless of clk.
// TESTING
//  T1 DIGITS=4, CLK_DIV=4, HEX, up, en=1 -> tick every 4th clk; count 0,1,2..; seg digit0 = ~7'h06 one cycle after count=1.
//  T2 BCD, load 16'h9998, up -> steps 9999 then 0000 with wrap=1 on that step only; seg all = ~7'h3F.
//  T3 BCD, down from 0000 -> 9999, wrap=1; HEX down from 0 -> 16'hFFFF, wrap=1.
//  T4 BIN, DIGITS=4, up 16 steps -> count 0..15 then 0; at count=4'b0101 seg digits 3..0 = '0','1','0','1'.
//  T5 BCD load 16'h3AF7 -> count=16'h3997; HEX load 16'hBEEF then switch mode to BCD -> count=0, no wrap.
//  T6 assert reset mid-prescale with en=1 -> count=0, tick=0, seg='0' immediately; en=0 for 10 clks -> no tick.

Source files
------------

// File: rtl/counter_7seg_multi.sv
// counter_7seg_multi: N-digit up/down counter with prescaler and 7-segment drive.
// The display can show the count as per-bit binary, hexadecimal or BCD decimal.
// tick marks each count step. wrap marks a step that rolls over.
module counter_7seg_multi #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [7*DIGITS-1:0]   seg,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [W-1:0]  CNT_ONE    = W'(1);
  localparam logic [W-1:0]  BIN_MAX    = W'((64'd1 << DIGITS) - 64'd1);

  localparam logic [1:0] MODE_BIN = 2'b00;
  localparam logic [1:0] MODE_BCD = 2'b10;

  localparam logic [6:0] GLYPH_ZERO = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;

  logic [PW-1:0]      presc;
  logic [1:0]         mode_q;
  logic               step_now;
  logic [W-1:0]       next_step;
  logic               step_wrap;
  logic               carry;
  logic [3:0]         nib;
  logic [W-1:0]       load_san;
  logic [7*DIGITS-1:0] seg_next;

  // Convert one nibble to its gfedcba glyph, already at the board's lit polarity.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    g = 7'h3F;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
    endcase
    return SEG_ACTIVE_LOW ? ~g : g;
  endfunction

  // A step happens when the prescaler reaches the end of its period while enabled.
  assign step_now = en && (presc == PRESC_LAST);

  // Compute the next count value and whether this step rolls over.
  // Mode 11 falls through to the hex case.
  always_comb begin
    next_step = count;
    step_wrap = 1'b0;
    carry     = 1'b1;
    nib       = 4'h0;
    case (mode_q)
      MODE_BIN: begin
        if (up) begin
          step_wrap = (count == BIN_MAX);
          next_step = step_wrap ? '0 : count + CNT_ONE;
        end else begin
          step_wrap = (count == '0);
          next_step = step_wrap ? BIN_MAX : count - CNT_ONE;
        end
      end
      MODE_BCD: begin
        for (int i = 0; i < DIGITS; i++) begin
          nib = count[4*i +: 4];
          if (carry) begin
            if (up) begin
              if (nib == 4'd9) nib = 4'd0;
              else begin
                nib   = nib + 4'd1;
                carry = 1'b0;
              end
            end else begin
              if (nib == 4'd0) nib = 4'd9;
              else begin
                nib   = nib - 4'd1;
                carry = 1'b0;
              end
            end
          end
          next_step[4*i +: 4] = nib;
        end
        step_wrap = carry;
      end
      default: begin
        if (up) begin
          step_wrap = (count == '1);
          next_step = count + CNT_ONE;
        end else begin
          step_wrap = (count == '0);
          next_step = count - CNT_ONE;
        end
      end
    endcase
  end

  // Bring a load value into the legal range of the current mode.
  always_comb begin
    load_san = load_val;
    case (mode_q)
      MODE_BIN: load_san = load_val & BIN_MAX;
      MODE_BCD: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (load_val[4*i +: 4] > 4'd9) load_san[4*i +: 4] = 4'd9;
        end
      end
      default: ;
    endcase
  end

  // Build the glyphs for every digit from the current count.
  always_comb begin
    seg_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (mode_q == MODE_BIN) seg_next[7*i +: 7] = glyph({3'b000, count[i]});
      else                    seg_next[7*i +: 7] = glyph(count[4*i +: 4]);
    end
  end

  // Update the counter state. A mode change has priority over a load, and a load has priority over a step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      count  <= '0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
      mode_q <= mode;
    end else if (mode != mode_q) begin
      mode_q <= mode;
      presc  <= '0;
      count  <= '0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else if (load) begin
      count <= load_san;
      presc <= '0;
      tick  <= step_now;
      wrap  <= 1'b0;
    end else if (en) begin
      presc <= step_now ? '0 : presc + PRESC_ONE;
      tick  <= step_now;
      wrap  <= step_now && step_wrap;
      if (step_now) count <= next_step;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

  // Register the segment outputs so that the display trails the count by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg <= {DIGITS{GLYPH_ZERO}};
    else       seg <= seg_next;
  end

endmodule

// File: tb/tb_counter_7seg_multi.sv
// tb_counter_7seg_multi: directed vector bench for counter_7seg_multi.
// Configuration: DIGITS=4, CLK_DIV=4, active-low segments.
module tb_counter_7seg_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        up;
  logic [1:0]  mode;
  logic        load;
  logic [15:0] load_val;
  logic [27:0] seg;
  logic [15:0] count;
  logic        tick;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic        up;
    logic [1:0]  mode;
    logic        ld;
    logic [15:0] lv;
    int          cyc;
    logic [15:0] ec;
    logic        et;
    logic        ew;
    logic        cs;
    logic [27:0] es;
  } vec_t;

  vec_t vecs[$];

  counter_7seg_multi #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .mode(mode), .load(load),
    .load_val(load_val), .seg(seg), .count(count), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Compare one value and record the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive the inputs and run n clocks. load is held for the first cycle only. The task returns on a negedge.
  task automatic applyStimulus(input logic e, input logic u, input logic [1:0] m,
                               input logic ld, input logic [15:0] lv, input int n);
    en = e; up = u; mode = m; load = ld; load_val = lv;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1 load = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    // The tuple order is {en, up, mode, load, load_val, cycles, count, tick, wrap, check_seg, seg}.
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b01, 1'b1, 16'h1234, 1,  16'h1234, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b01, 1'b0, 16'h0000, 4,  16'h1235, 1'b1, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b01, 1'b0, 16'h0000, 4,  16'h1234, 1'b1, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 2'b01, 1'b0, 16'h0000, 10, 16'h1234, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 2'b01, 1'b1, 16'hFFFF, 1,  16'hFFFF, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b01, 1'b0, 16'h0000, 4,  16'h0000, 1'b1, 1'b1, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b01, 1'b0, 16'h0000, 4,  16'hFFFF, 1'b1, 1'b1, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b10, 1'b0, 16'h0000, 1,  16'h0000, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b10, 1'b0, 16'h0000, 4,  16'h9999, 1'b1, 1'b1, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 2'b10, 1'b1, 16'h3AF7, 1,  16'h3997, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 2'b10, 1'b0, 16'h0000, 1,  16'h3997, 1'b0, 1'b0, 1'b1,
                          {7'h30, 7'h10, 7'h10, 7'h78}});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b10, 1'b1, 16'h9998, 1,  16'h9998, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b10, 1'b0, 16'h0000, 4,  16'h9999, 1'b1, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b10, 1'b0, 16'h0000, 4,  16'h0000, 1'b1, 1'b1, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b10, 1'b0, 16'h0000, 1,  16'h0000, 1'b0, 1'b0, 1'b1,
                          {7'h40, 7'h40, 7'h40, 7'h40}});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b10, 1'b1, 16'h0199, 1,  16'h0199, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b10, 1'b0, 16'h0000, 4,  16'h0200, 1'b1, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b10, 1'b0, 16'h0000, 4,  16'h0199, 1'b1, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b00, 1'b0, 16'h0000, 1,  16'h0000, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 2'b00, 1'b1, 16'hABC5, 1,  16'h0005, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 1,  16'h0005, 1'b0, 1'b0, 1'b1,
                          {7'h40, 7'h79, 7'h40, 7'h79}});
    vecs.push_back(vec_t'{1'b0, 1'b1, 2'b00, 1'b1, 16'hABCD, 1,  16'h000D, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b00, 1'b0, 16'h0000, 4,  16'h000E, 1'b1, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b00, 1'b0, 16'h0000, 4,  16'h000F, 1'b1, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b00, 1'b0, 16'h0000, 4,  16'h0000, 1'b1, 1'b1, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 4,  16'h000F, 1'b1, 1'b1, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b11, 1'b0, 16'h0000, 1,  16'h0000, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 2'b11, 1'b1, 16'hBEEF, 1,  16'hBEEF, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 1,  16'hBEEF, 1'b0, 1'b0, 1'b1,
                          {7'h03, 7'h06, 7'h06, 7'h0E}});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b10, 1'b1, 16'h1234, 1,  16'h0000, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b10, 1'b0, 16'h0000, 3,  16'h0000, 1'b0, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b10, 1'b1, 16'h0042, 1,  16'h0042, 1'b1, 1'b0, 1'b0, 28'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b10, 1'b0, 16'h0000, 4,  16'h0043, 1'b1, 1'b0, 1'b0, 28'h0});

    // Reset value check.
    reset = 1'b1; en = 1'b0; up = 1'b1; mode = 2'b01; load = 1'b0; load_val = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset count", 32'(count), 32'h0);
    checkOutput("reset tick", 32'(tick), 32'h0);
    checkOutput("reset wrap", 32'(wrap), 32'h0);
    checkOutput("reset seg", 32'(seg), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    reset = 1'b0;

    // Prescaled hex stepping from reset, followed by the display latency.
    $display("[TB] hex prescale from reset");
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 16'h0, 1);
      checkOutput($sformatf("t1 tick c%0d", c), 32'(tick), (c == 4) ? 32'h1 : 32'h0);
      checkOutput($sformatf("t1 count c%0d", c), 32'(count), (c == 4) ? 32'h1 : 32'h0);
    end
    checkOutput("t1 seg before latency", 32'(seg), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 16'h0, 1);
    checkOutput("t1 tick after", 32'(tick), 32'h0);
    checkOutput("t1 seg digit0 one", 32'(seg), 32'({7'h40, 7'h40, 7'h40, 7'h79}));

    // Table of directed vectors.
    $display("[TB] vector table, %0d entries", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].up, vecs[i].mode, vecs[i].ld, vecs[i].lv, vecs[i].cyc);
      checkOutput($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].ec));
      checkOutput($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].et));
      checkOutput($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].ew));
      if (vecs[i].cs) checkOutput($sformatf("vec%0d seg", i), 32'(seg), 32'(vecs[i].es));
    end

    // Full binary cycle: sixteen steps go 1..15 and then wrap to 0.
    $display("[TB] binary full cycle");
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 16'h0, 1);
    checkOutput("bin start count", 32'(count), 32'h0);
    for (int s = 0; s < 16; s++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 16'h0, 4);
      checkOutput($sformatf("bin step%0d count", s), 32'(count), 32'((s + 1) % 16));
      checkOutput($sformatf("bin step%0d wrap", s), 32'(wrap), (s == 15) ? 32'h1 : 32'h0);
    end

    // Reset asserted mid-prescale takes effect without a clock edge.
    $display("[TB] async reset mid-count");
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 16'h0, 1);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 16'h0055, 1);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 16'h0, 2);
    checkOutput("t6 pre-reset count", 32'(count), 32'h0055);
    reset = 1'b1;
    #1;
    checkOutput("t6 async count", 32'(count), 32'h0);
    checkOutput("t6 async tick", 32'(tick), 32'h0);
    checkOutput("t6 async seg", 32'(seg), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    @(negedge clk);
    en = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 16'h0, 1);
      checkOutput($sformatf("t6 idle tick c%0d", c), 32'(tick), 32'h0);
    end
    checkOutput("t6 idle count", 32'(count), 32'h0);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 16'h0, 4);
    checkOutput("t6 resume count", 32'(count), 32'h1);
    checkOutput("t6 resume tick", 32'(tick), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
